// File: rtl/seg_scan_ctrl.sv
// Scan controller: steps a shared 3-bit segment encoder and a one-hot digit enable
// across NUM_DIGITS digits with a blank gap; optional blinking under SEG_SCAN_BLINK_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int IDX_W        = 2,
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
`ifdef SEG_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [2:0]            wr_code,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic                  enc_a,
  output logic                  enc_b,
  output logic                  enc_c,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      cur_idx, idx_nxt, idx_inc;
  logic [2:0]            enc_q, enc_nxt, show_code;
  logic [NUM_DIGITS-1:0] dig_nxt, show_onehot;
  logic                  fd_nxt, show_go, wr_fire;
  logic [2:0]            code_q [NUM_DIGITS];

`ifdef SEG_SCAN_BLINK_EN
  localparam int FCNT_W = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES);
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic              blink_phase, phase_nxt;
`endif

  // The lit digit is write-protected so its segments never change mid-dwell.
  assign wr_ready = rst_n && !((state == SHOW) && (wr_idx == cur_idx));
  assign wr_fire  = wr_valid && wr_ready;

  assign enc_a = enc_q[2];
  assign enc_b = enc_q[1];
  assign enc_c = enc_q[0];

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = cur_idx;
    enc_nxt     = enc_q;
    dig_nxt     = dig_en;
    fd_nxt      = 1'b0;
    show_go     = 1'b0;
    show_code   = '0;
    show_onehot = '0;
    idx_inc     = (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);

    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      dig_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (BLANK_CYCLES == 0) begin
            show_go = 1'b1;
          end else begin
            state_nxt = BLANK;
            cnt_nxt   = CNT_W'(BLANK_CYCLES);
          end
        end
        BLANK: begin
          if (cnt <= CNT_W'(1)) show_go = 1'b1;
          else                  cnt_nxt = cnt - CNT_W'(1);
        end
        SHOW: begin
          if (cnt <= CNT_W'(1)) begin
            dig_nxt = '0;
            idx_nxt = idx_inc;
            fd_nxt  = (cur_idx == LAST_IDX);
            if (BLANK_CYCLES == 0) begin
              show_go = 1'b1;
            end else begin
              state_nxt = BLANK;
              cnt_nxt   = CNT_W'(BLANK_CYCLES);
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Code lookup uses the pre-edge register value, so a same-edge write shows next slot.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        show_code      = code_q[i];
        show_onehot[i] = 1'b1;
      end
    end

    if (show_go) begin
      state_nxt = SHOW;
      cnt_nxt   = CNT_W'(DWELL_CYCLES);
      enc_nxt   = show_code;
      dig_nxt   = show_onehot;
    end

`ifdef SEG_SCAN_BLINK_EN
    fcnt_nxt  = fcnt;
    phase_nxt = blink_phase;
    if (!enable) begin
      fcnt_nxt  = '0;
      phase_nxt = 1'b0;
    end else if (fd_nxt) begin
      if (fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
        fcnt_nxt  = '0;
        phase_nxt = ~blink_phase;
      end else begin
        fcnt_nxt = fcnt + FCNT_W'(1);
      end
    end
    // Gate with the upcoming phase so a zero-blank scan still blinks on time.
    if (phase_nxt) dig_nxt = dig_nxt & ~blink_mask;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_idx    <= '0;
      enc_q      <= '0;
      dig_en     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_idx    <= idx_nxt;
      enc_q      <= enc_nxt;
      dig_en     <= dig_nxt;
      frame_done <= fd_nxt;
    end
  end

  // Out-of-range indices match no slot, so those writes are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) code_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_fire && (wr_idx == IDX_W'(i))) code_q[i] <= wr_code;
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt        <= '0;
      blink_phase <= 1'b0;
    end else begin
      fcnt        <= fcnt_nxt;
      blink_phase <= phase_nxt;
    end
  end
`endif

endmodule
